// File: rtl/npc_fetch_if.sv
// npc_fetch_if: D-stage control-transfer inputs, hazard stall and F-stage PC outputs of the fetch unit.
interface npc_fetch_if;
  logic        stall;
  logic [2:0]  br_type;
  logic        cmp_eq;
  logic [31:0] d_pc;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_value;
  logic [31:0] f_pc;
  logic [31:0] f_pc_plus4;
  logic        redirect;
  logic        flush_fd;
  logic        pc_misalign;
  modport master (
    output stall, br_type, cmp_eq, d_pc, imm16, instr_index, rs_value,
    input  f_pc, f_pc_plus4, redirect, flush_fd, pc_misalign
  );
  modport slave (
    input  stall, br_type, cmp_eq, d_pc, imm16, instr_index, rs_value,
    output f_pc, f_pc_plus4, redirect, flush_fd, pc_misalign
  );
endinterface

// File: rtl/npc_fetch.sv
// npc_fetch: F-stage PC register and next-PC select; NPC_DELAY_SLOT_EN keeps the delay-slot fetch instead of flushing it.
module npc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic       clk,
  input logic       reset,
  npc_fetch_if.slave bus
);
  logic [31:0] seq_pc, br_target, target, next_pc;
  logic        taken;
  assign bus.f_pc_plus4 = bus.f_pc + 32'd4;
  always_comb begin
    seq_pc    = bus.d_pc + 32'd4;
    br_target = seq_pc + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    taken     = ((bus.br_type == 3'd1) & bus.cmp_eq) | ((bus.br_type == 3'd2) & ~bus.cmp_eq) |
                (bus.br_type == 3'd3) | (bus.br_type == 3'd4);
    target    = (bus.br_type == 3'd3) ? {seq_pc[31:28], bus.instr_index, 2'b00} :
                (bus.br_type == 3'd4) ? bus.rs_value : br_target;
    bus.redirect = taken & ~bus.stall;
    next_pc   = bus.stall ? bus.f_pc : bus.redirect ? target : bus.f_pc_plus4;
  end
`ifdef NPC_DELAY_SLOT_EN
  assign bus.flush_fd = 1'b0;
`else
  assign bus.flush_fd = bus.redirect;
`endif
  // misalign is sticky: once an unaligned PC was fetched, only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.f_pc        <= RESET_PC;
      bus.pc_misalign <= 1'b0;
    end else begin
      bus.f_pc        <= next_pc;
      bus.pc_misalign <= bus.pc_misalign | (|next_pc[1:0]);
    end
  end
endmodule

// File: tb/tb_npc_fetch.sv
// tb_npc_fetch: vector table driven into npc_fetch; post-edge PC/misalign expectations go through a queue.
module tb_npc_fetch;
  logic clk = 1'b0;
  logic reset;
  npc_fetch_if bus();
  npc_fetch dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  bt;
    logic        eq;
    logic [31:0] d_pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        red;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  logic [31:0] prev_pc;
  logic        prev_valid = 1'b0;

  function automatic vec_t mk(logic rst, logic stall, logic [2:0] bt, logic eq, logic [31:0] d_pc,
                              logic [15:0] imm, logic [25:0] idx, logic [31:0] rs,
                              logic red, logic [31:0] pc, logic mis);
    vec_t v;
    v.rst = rst; v.stall = stall; v.bt = bt; v.eq = eq; v.d_pc = d_pc; v.imm = imm;
    v.idx = idx; v.rs = rs; v.red = red; v.pc = pc; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    exp_t e;
    logic exp_flush;
    @(negedge clk);
    reset = v.rst; bus.stall = v.stall; bus.br_type = v.bt; bus.cmp_eq = v.eq; bus.d_pc = v.d_pc;
    bus.imm16 = v.imm; bus.instr_index = v.idx; bus.rs_value = v.rs;
`ifdef NPC_DELAY_SLOT_EN
    exp_flush = 1'b0;
`else
    exp_flush = v.red;
`endif
    #1;
    chk({tag, " redirect"}, {31'd0, bus.redirect}, {31'd0, v.red});
    chk({tag, " flush_fd"}, {31'd0, bus.flush_fd}, {31'd0, exp_flush});
    if (prev_valid) chk({tag, " f_pc_plus4"}, bus.f_pc_plus4, prev_pc + 32'd4);
    e.pc = v.pc; e.mis = v.mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " f_pc"}, bus.f_pc, e.pc);
    chk({tag, " pc_misalign"}, {31'd0, bus.pc_misalign}, {31'd0, e.mis});
    prev_pc = e.pc; prev_valid = 1'b1;
  endtask

  initial begin
    vecs.push_back(mk(1, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h3000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h3000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h3004, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h3008, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h3010,     16'hFFFC, 26'h0,     0,            1, 32'h3004, 0));
    vecs.push_back(mk(0, 0, 2, 1, 32'h3020,     16'h0010, 26'h0,     0,            0, 32'h3008, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h300C, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h3010,     16'hFFFC, 26'h0,     0,            0, 32'h300C, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h3010,     16'hFFFC, 26'h0,     0,            0, 32'h300C, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h3010,     16'hFFFC, 26'h0,     0,            0, 32'h300C, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h3010,     16'hFFFC, 26'h0,     0,            1, 32'h3004, 0));
    vecs.push_back(mk(0, 0, 3, 0, 32'h3FFC,     16'h0,    26'hC10,   0,            1, 32'h3040, 0));
    vecs.push_back(mk(0, 0, 3, 1, 32'hEFFFFFFC, 16'h0,    26'h0,     0,            1, 32'hF0000000, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0,            16'h0,    26'h0,     32'h3042,     1, 32'h3042, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h3046, 1));
    vecs.push_back(mk(0, 0, 4, 1, 0,            16'h0,    26'h0,     32'h3000,     1, 32'h3000, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'h3010,     16'hFFFC, 26'h0,     0,            0, 32'h3004, 1));
    vecs.push_back(mk(0, 0, 2, 0, 32'h3020,     16'h0010, 26'h0,     0,            1, 32'h3064, 1));
    vecs.push_back(mk(1, 0, 1, 1, 32'h3010,     16'hFFFC, 26'h0,     0,            1, 32'h3000, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0,            16'h0,    26'h0,     32'h5000,     0, 32'h3000, 0));
    vecs.push_back(mk(0, 0, 7, 0, 0,            16'h0,    26'h0,     0,            0, 32'h3004, 0));
    vecs.push_back(mk(0, 0, 5, 1, 0,            16'h0,    26'h0,     0,            0, 32'h3008, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0,            16'h0,    26'h0,     32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            16'h0,    26'h0,     0,            0, 32'h00000000, 0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));
    // stalled branch re-evaluated with the comparator value present when the stall drops
    apply(mk(0, 1, 1, 0, 32'h3100, 16'h0008, 26'h0, 0, 0, 32'h00000000, 0), "reeval0");
    apply(mk(0, 0, 1, 0, 32'h3100, 16'h0008, 26'h0, 0, 0, 32'h00000004, 0), "reeval1");
    apply(mk(0, 1, 1, 1, 32'h3100, 16'h0008, 26'h0, 0, 0, 32'h00000004, 0), "reeval2");
    apply(mk(0, 0, 1, 1, 32'h3100, 16'h0008, 26'h0, 0, 1, 32'h00003124, 0), "reeval3");
    apply(mk(1, 1, 4, 0, 0, 16'h0, 26'h0, 32'h7000, 0, 32'h00003000, 0), "rst_stall");
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
